// File: rtl/dsp_preadd_bpath.sv
// dsp_preadd_bpath: B-input / pre-adder path of a DSP slice.
// Configurable-depth delay lines on D, B (or BCIN) and OPMODE feed an
// unsigned pre-adder. The result, the overflow flag and a valid bit then
// pass through a second delay line to BCOUT/OVF/OUT_VALID.
// Every stage has its own section clock enable and clears asynchronously
// on RST. A depth of 0 turns that section into a plain wire.
module dsp_preadd_bpath #(
    parameter int WIDTH   = 18,
    parameter int DDEPTH  = 1,
    parameter int B0DEPTH = 1,
    parameter int B1DEPTH = 1,
    parameter int OPREG   = 1,
    parameter     B_INPUT = "DIRECT",
    parameter int SAT     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CED,
    input  logic             CEB0,
    input  logic             CEB1,
    input  logic             CEOPMODE,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] BCIN,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       OPMODE,
    output logic [WIDTH-1:0] BCOUT,
    output logic             OVF,
    output logic             OUT_VALID
);

    genvar gi;

    // B source is fixed at elaboration time. The operand that is not
    // selected is folded into a dummy net so it is not left dangling.
    logic [WIDTH-1:0] bsrc;
    logic             unused_bsrc;
    generate
        if (B_INPUT == "CASCADE") begin : g_src_casc
            assign bsrc        = BCIN;
            assign unused_bsrc = ^B;
        end else begin : g_src_direct
            assign bsrc        = B;
            assign unused_bsrc = ^BCIN;
        end
    endgenerate

    // D delay line. Tap 0 is the raw input, and tap N is the output of stage N.
    logic [WIDTH-1:0] d_tap [0:DDEPTH];
    assign d_tap[0] = D;
    generate
        for (gi = 0; gi < DDEPTH; gi++) begin : g_d
            logic [WIDTH-1:0] d_d;
            logic [WIDTH-1:0] d_q;
            // Capture the previous tap when enabled. Hold otherwise.
            always_comb d_d = CED ? d_tap[gi] : d_q;
            // Stage register with asynchronous clear.
            always_ff @(posedge CLK or posedge RST)
                if (RST) d_q <= '0;
                else     d_q <= d_d;
            assign d_tap[gi+1] = d_q;
        end
    endgenerate

    // B0 delay line. The valid bit is carried in the MSB so it stays aligned with B.
    logic [WIDTH:0] b0_tap [0:B0DEPTH];
    assign b0_tap[0] = {IN_VALID, bsrc};
    generate
        for (gi = 0; gi < B0DEPTH; gi++) begin : g_b0
            logic [WIDTH:0] b0_d;
            logic [WIDTH:0] b0_q;
            // Capture the previous tap when enabled. Hold otherwise.
            always_comb b0_d = CEB0 ? b0_tap[gi] : b0_q;
            // Stage register with asynchronous clear.
            always_ff @(posedge CLK or posedge RST)
                if (RST) b0_q <= '0;
                else     b0_q <= b0_d;
            assign b0_tap[gi+1] = b0_q;
        end
    endgenerate

    // OPMODE delay line (zero or one stage).
    logic [1:0] op_tap [0:OPREG];
    assign op_tap[0] = OPMODE;
    generate
        for (gi = 0; gi < OPREG; gi++) begin : g_op
            logic [1:0] op_d;
            logic [1:0] op_q;
            // Capture the previous tap when enabled. Hold otherwise.
            always_comb op_d = CEOPMODE ? op_tap[gi] : op_q;
            // Stage register with asynchronous clear.
            always_ff @(posedge CLK or posedge RST)
                if (RST) op_q <= '0;
                else     op_q <= op_d;
            assign op_tap[gi+1] = op_q;
        end
    endgenerate

    // Pre-adder operands. These may come from different cycles when the depths differ.
    logic [WIDTH-1:0] pre_d;
    logic [WIDTH-1:0] pre_b;
    logic             pre_v;
    logic [1:0]       pre_op;
    assign pre_d          = d_tap[DDEPTH];
    assign {pre_v, pre_b} = b0_tap[B0DEPTH];
    assign pre_op         = op_tap[OPREG];

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] pre_r;
    logic             pre_ovf;

    // Unsigned add/sub. The extra MSB is the carry (add) or the borrow (sub).
    // With saturation enabled, overflow clamps to all ones and underflow clamps to zero.
    always_comb begin
        sum_s   = {1'b0, pre_d} + {1'b0, pre_b};
        diff_s  = {1'b0, pre_d} - {1'b0, pre_b};
        pre_r   = pre_b;
        pre_ovf = 1'b0;
        if (pre_op[0]) begin
            if (!pre_op[1]) begin
                pre_ovf = sum_s[WIDTH];
                pre_r   = (SAT != 0 && sum_s[WIDTH]) ? '1 : sum_s[WIDTH-1:0];
            end else begin
                pre_ovf = diff_s[WIDTH];
                pre_r   = (SAT != 0 && diff_s[WIDTH]) ? '0 : diff_s[WIDTH-1:0];
            end
        end
    end

    // B1 delay line carries {valid, ovf, result} to the outputs.
    logic [WIDTH+1:0] b1_tap [0:B1DEPTH];
    assign b1_tap[0] = {pre_v, pre_ovf, pre_r};
    generate
        for (gi = 0; gi < B1DEPTH; gi++) begin : g_b1
            logic [WIDTH+1:0] b1_d;
            logic [WIDTH+1:0] b1_q;
            // Capture the previous tap when enabled. Hold otherwise.
            always_comb b1_d = CEB1 ? b1_tap[gi] : b1_q;
            // Stage register with asynchronous clear.
            always_ff @(posedge CLK or posedge RST)
                if (RST) b1_q <= '0;
                else     b1_q <= b1_d;
            assign b1_tap[gi+1] = b1_q;
        end
    endgenerate

    assign {OUT_VALID, OVF, BCOUT} = b1_tap[B1DEPTH];

endmodule

// File: tb/tb_dsp_preadd_bpath.sv
// Testbench for dsp_preadd_bpath. Directed vectors run on three default-depth
// instances (wrap, saturate, cascade source). After that, all 64 depth
// combinations are swept against a delayed reference model.
module tb_dsp_preadd_bpath;

    localparam int W   = 18;
    localparam int PAD = 8;
    localparam int NS  = 24;

    logic          clk;
    logic          rst;
    logic          ced, ceb0, ceb1, ceop;
    logic          in_valid;
    logic [W-1:0]  b, bcin, d;
    logic [1:0]    op;

    logic [W-1:0]  dflt_bcout, sat_bcout, casc_bcout;
    logic          dflt_ovf, sat_ovf, casc_ovf;
    logic          dflt_vld, sat_vld, casc_vld;

    logic [W-1:0]  sw_bcout [0:63];
    logic          sw_ovf   [0:63];
    logic          sw_vld   [0:63];

    int            n_errors = 0;
    int            n_checks = 0;

    logic [W-1:0]  hd  [0:PAD+NS-1];
    logic [W-1:0]  hb  [0:PAD+NS-1];
    logic [1:0]    hop [0:PAD+NS-1];
    logic          hv  [0:PAD+NS-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dsp_preadd_bpath u_dflt (
        .CLK(clk), .RST(rst), .CED(ced), .CEB0(ceb0), .CEB1(ceb1),
        .CEOPMODE(ceop), .IN_VALID(in_valid), .B(b), .BCIN(bcin), .D(d),
        .OPMODE(op), .BCOUT(dflt_bcout), .OVF(dflt_ovf), .OUT_VALID(dflt_vld)
    );

    dsp_preadd_bpath #(.SAT(1)) u_sat (
        .CLK(clk), .RST(rst), .CED(ced), .CEB0(ceb0), .CEB1(ceb1),
        .CEOPMODE(ceop), .IN_VALID(in_valid), .B(b), .BCIN(bcin), .D(d),
        .OPMODE(op), .BCOUT(sat_bcout), .OVF(sat_ovf), .OUT_VALID(sat_vld)
    );

    dsp_preadd_bpath #(.B_INPUT("CASCADE")) u_casc (
        .CLK(clk), .RST(rst), .CED(ced), .CEB0(ceb0), .CEB1(ceb1),
        .CEOPMODE(ceop), .IN_VALID(in_valid), .B(b), .BCIN(bcin), .D(d),
        .OPMODE(op), .BCOUT(casc_bcout), .OVF(casc_ovf), .OUT_VALID(casc_vld)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_sweep
            dsp_preadd_bpath #(
                .DDEPTH(gi / 16), .B0DEPTH((gi / 4) % 4), .B1DEPTH(gi % 4),
                .OPREG((((gi / 4) % 4) > 0) ? 1 : 0)
            ) u_sw (
                .CLK(clk), .RST(rst), .CED(ced), .CEB0(ceb0), .CEB1(ceb1),
                .CEOPMODE(ceop), .IN_VALID(in_valid), .B(b), .BCIN(bcin), .D(d),
                .OPMODE(op), .BCOUT(sw_bcout[gi]), .OVF(sw_ovf[gi]),
                .OUT_VALID(sw_vld[gi])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] bv, input logic [W-1:0] dv,
                         input logic [1:0] opv, input logic vv);
        b = bv; d = dv; op = opv; in_valid = vv;
    endtask

    // Advance one rising edge, then return on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic show(input string name);
        $display("tx %-12s bcout=0x%05h ovf=%0b vld=%0b | sat=0x%05h/%0b casc=0x%05h",
                 name, dflt_bcout, dflt_ovf, dflt_vld, sat_bcout, sat_ovf, casc_bcout);
    endtask

    // Independent unsigned pre-add reference: returns {ovf, result}.
    function automatic logic [W:0] ref_preadd(input logic [W-1:0] dv, input logic [W-1:0] bv,
                                              input logic [1:0] opv, input bit sat);
        int unsigned s;
        logic        ov;
        logic [W-1:0] r;
        if (!opv[0]) return {1'b0, bv};
        if (!opv[1]) begin
            s  = 32'(dv) + 32'(bv);
            ov = (s > 32'd262143);
            r  = ov ? (sat ? 18'h3FFFF : 18'(s - 32'd262144)) : 18'(s);
        end else begin
            ov = (dv < bv);
            r  = ov ? (sat ? 18'h0 : 18'(32'd262144 + 32'(dv) - 32'(bv))) : 18'(32'(dv) - 32'(bv));
        end
        return {ov, r};
    endfunction

    initial begin
        rst = 1'b1; ced = 1'b1; ceb0 = 1'b1; ceb1 = 1'b1; ceop = 1'b1;
        bcin = '0;
        drive('0, '0, 2'b00, 1'b0);
        for (int i = 0; i < PAD + NS; i++) begin
            hd[i] = '0; hb[i] = '0; hop[i] = '0; hv[i] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        show("reset");
        check_eq("reset_bcout", dflt_bcout, 0);
        check_eq("reset_ovf",   dflt_ovf,   0);
        check_eq("reset_vld",   dflt_vld,   0);
        rst = 1'b0;

        // Bypass: exactly two cycles of latency; D has no effect
        cyc(); cyc(); cyc();
        drive(18'h01234, 18'h3FFFF, 2'b00, 1'b1);
        cyc();
        check_eq("bypass_lat1_vld", dflt_vld, 0);
        d = 18'h00007;
        cyc();
        show("bypass");
        check_eq("bypass_bcout", dflt_bcout, 32'h01234);
        check_eq("bypass_vld",   dflt_vld,   1);
        check_eq("bypass_ovf",   dflt_ovf,   0);

        // Add and subtract
        drive(18'd25, 18'd100, 2'b01, 1'b1);
        cyc(); cyc();
        show("add");
        check_eq("add_bcout", dflt_bcout, 125);
        check_eq("add_ovf",   dflt_ovf,   0);
        op = 2'b11;
        cyc(); cyc();
        show("sub");
        check_eq("sub_bcout", dflt_bcout, 75);
        check_eq("sub_ovf",   dflt_ovf,   0);

        // Wrap vs saturate: subtract underflow
        drive(18'd10, 18'd5, 2'b11, 1'b1);
        cyc(); cyc();
        show("sub_under");
        check_eq("wrap_sub_bcout", dflt_bcout, 262139);
        check_eq("wrap_sub_ovf",   dflt_ovf,   1);
        check_eq("sat_sub_bcout",  sat_bcout,  0);
        check_eq("sat_sub_ovf",    sat_ovf,    1);

        // Wrap vs saturate: add overflow
        drive(18'd1, 18'h3FFFF, 2'b01, 1'b1);
        cyc(); cyc();
        show("add_over");
        check_eq("wrap_add_bcout", dflt_bcout, 0);
        check_eq("wrap_add_ovf",   dflt_ovf,   1);
        check_eq("sat_add_bcout",  sat_bcout,  32'h3FFFF);
        check_eq("sat_add_ovf",    sat_ovf,    1);

        // Cascade source
        drive(18'd0, 18'd0, 2'b00, 1'b1);
        bcin = 18'h00ABC;
        cyc(); cyc();
        show("cascade");
        check_eq("casc_bcout",   casc_bcout, 32'h00ABC);
        check_eq("direct_bcout", dflt_bcout, 0);

        // Mid-stream reset clears the outputs at once
        drive(18'd2, 18'h3FFFF, 2'b01, 1'b1);
        cyc(); cyc();
        show("pre_reset");
        check_eq("prerst_bcout", dflt_bcout, 1);
        check_eq("prerst_ovf",   dflt_ovf,   1);
        rst = 1'b1;
        #1;
        show("in_reset");
        check_eq("rst_bcout", dflt_bcout, 0);
        check_eq("rst_ovf",   dflt_ovf,   0);
        check_eq("rst_vld",   dflt_vld,   0);
        drive(18'h00555, 18'd0, 2'b00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check_eq("rel1_bcout", dflt_bcout, 0);
        check_eq("rel1_vld",   dflt_vld,   0);
        cyc();
        show("post_reset");
        check_eq("rel2_bcout", dflt_bcout, 32'h00555);
        check_eq("rel2_vld",   dflt_vld,   1);

        // CEB1 low for three cycles: outputs freeze, B0 keeps advancing
        drive(18'h00101, 18'd0, 2'b00, 1'b1); cyc();
        drive(18'h00102, 18'd0, 2'b00, 1'b1); cyc();
        check_eq("ce_pre_bcout", dflt_bcout, 32'h101);
        for (int i = 0; i < 3; i++) begin
            drive(18'(32'h103 + i), 18'd0, 2'b00, 1'b0);
            ceb1 = 1'b0;
            cyc();
            show("ceb1_low");
            check_eq($sformatf("freeze%0d_bcout", i), dflt_bcout, 32'h101);
            check_eq($sformatf("freeze%0d_vld", i),   dflt_vld,   1);
        end
        drive(18'h00106, 18'd0, 2'b00, 1'b1);
        ceb1 = 1'b1;
        cyc();
        show("ceb1_rel");
        check_eq("resume1_bcout", dflt_bcout, 32'h105);
        check_eq("resume1_vld",   dflt_vld,   0);
        drive(18'h00107, 18'd0, 2'b00, 1'b1);
        cyc();
        check_eq("resume2_bcout", dflt_bcout, 32'h106);
        check_eq("resume2_vld",   dflt_vld,   1);

        // Depth sweep: every instance against the delayed reference
        rst = 1'b1;
        bcin = '0;
        drive('0, '0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < NS; n++) begin
            if (n > 0) @(negedge clk);
            drive(18'($urandom), 18'($urandom), 2'($urandom), 1'($urandom));
            hd[PAD+n] = d; hb[PAD+n] = b; hop[PAD+n] = op; hv[PAD+n] = in_valid;
            #1;
            for (int k = 0; k < 64; k++) begin
                int dd, b0, b1, opr;
                logic [W:0] e;
                dd  = k / 16;
                b0  = (k / 4) % 4;
                b1  = k % 4;
                opr = (b0 > 0) ? 1 : 0;
                e = ref_preadd(hd[PAD+n-dd-b1], hb[PAD+n-b0-b1], hop[PAD+n-opr-b1], 1'b0);
                check_eq($sformatf("sweep_k%0d_n%0d_bcout", k, n), sw_bcout[k], 32'(e[W-1:0]));
                check_eq($sformatf("sweep_k%0d_n%0d_ovf", k, n),   sw_ovf[k],   32'(e[W]));
                check_eq($sformatf("sweep_k%0d_n%0d_vld", k, n),   sw_vld[k],   32'(hv[PAD+n-b0-b1]));
            end
            $display("tx sweep n=%0d d=0x%05h b=0x%05h op=%0b vld=%0b", n, d, b, op, in_valid);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
